// File: rtl/bp_pkg.sv
// bp_pkg: shared counter and FSM encodings for the branch target buffer.
package bp_pkg;
  typedef enum logic [1:0] {CTR_SNT = 2'b00, CTR_WNT = 2'b01, CTR_WT = 2'b10, CTR_ST = 2'b11} ctr_t;
  localparam ctr_t CTR_INIT = CTR_WT;
  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;
endpackage

// File: rtl/branch_target_buffer_if.sv
// branch_target_buffer_if: lookup, update and flush signals of the branch target buffer.
interface branch_target_buffer_if #(parameter int NRD = 2, parameter int DWIDTH = 32);
  logic [NRD-1:0] rd_en, rd_hit, rd_taken;
  logic [NRD*DWIDTH-1:0] rd_pc, rd_target;
  logic upd_en, upd_taken, flush_req, busy;
  logic [DWIDTH-1:0] upd_pc, upd_target;
  modport master(output rd_en, rd_pc, upd_en, upd_pc, upd_taken, upd_target, flush_req,
                 input rd_hit, rd_taken, rd_target, busy);
  modport slave(input rd_en, rd_pc, upd_en, upd_pc, upd_taken, upd_target, flush_req,
                output rd_hit, rd_taken, rd_target, busy);
endinterface

// File: rtl/bp_sat_counter.sv
// bp_sat_counter: 2-bit saturating direction counter next-state.
module bp_sat_counter
  import bp_pkg::*;
(
  input  ctr_t ctr,
  input  logic taken,
  output ctr_t nxt
);
  always_comb
    nxt = taken ? (ctr == CTR_ST ? CTR_ST : ctr_t'(ctr + 2'd1))
                : (ctr == CTR_SNT ? CTR_SNT : ctr_t'(ctr - 2'd1));
endmodule

// File: rtl/branch_target_buffer.sv
// branch_target_buffer: direct-mapped BTB with NRD registered lookup ports and FSM-driven flush.
module branch_target_buffer
  import bp_pkg::*;
#(
  parameter int AWIDTH = 6,
  parameter int TWIDTH = 8,
  parameter int DWIDTH = 32,
  parameter int NRD    = 2
) (
  input logic clk,
  input logic reset,
  branch_target_buffer_if.slave bus
);
  localparam int DEPTH = 2**AWIDTH;
  logic vld [DEPTH];
  logic [TWIDTH-1:0] tags [DEPTH];
  logic [DWIDTH-1:0] tgts [DEPTH];
  ctr_t ctrs [DEPTH];
  state_t state;
  logic [AWIDTH-1:0] clr_ptr, u_idx;
  logic [TWIDTH-1:0] u_tag;
  logic u_hit, u_we;
  ctr_t u_ctr, u_ctr_nxt;
  logic [DWIDTH-1:0] u_tgt;
  logic [DWIDTH-1:0] r_pc [NRD];
  logic [AWIDTH-1:0] r_idx [NRD];
  logic r_byp [NRD];
  logic [NRD-1:0] hit_n, tkn_n;
  logic [NRD*DWIDTH-1:0] tgt_n;
  always_comb begin
    u_idx = bus.upd_pc[AWIDTH+1:2];
    u_tag = bus.upd_pc[AWIDTH+TWIDTH+1:AWIDTH+2];
    u_hit = vld[u_idx] && tags[u_idx] == u_tag;
    u_we  = !reset && state == IDLE && bus.upd_en && !bus.flush_req && (u_hit || bus.upd_taken);
    u_ctr = u_hit ? u_ctr_nxt : CTR_INIT;
    u_tgt = bus.upd_taken ? bus.upd_target : tgts[u_idx];
  end
  bp_sat_counter u_sat (.ctr(ctrs[u_idx]), .taken(bus.upd_taken), .nxt(u_ctr_nxt));
  always_ff @(posedge clk)
    if (u_we) begin
      tags[u_idx] <= u_tag;
      tgts[u_idx] <= u_tgt;
      ctrs[u_idx] <= u_ctr;
    end
  always_ff @(posedge clk)
    if (state == CLEAR) vld[clr_ptr] <= 1'b0;
    else if (u_we) vld[u_idx] <= 1'b1;
  always_ff @(posedge clk)
    if (reset) begin
      state   <= CLEAR;
      clr_ptr <= '0;
    end else if (state == IDLE) begin
      if (bus.flush_req) begin
        state   <= CLEAR;
        clr_ptr <= '0;
      end
    end else begin
      clr_ptr <= clr_ptr + 1'b1;
      if (&clr_ptr) state <= IDLE;
    end
  assign bus.busy = state == CLEAR;
  // a read to the index being written sees the entry as it will be after this edge
  always_comb begin
    hit_n = '0;
    tkn_n = '0;
    tgt_n = '0;
    for (int i = 0; i < NRD; i++) begin
      r_pc[i]  = bus.rd_pc[i*DWIDTH +: DWIDTH];
      r_idx[i] = r_pc[i][AWIDTH+1:2];
      r_byp[i] = u_we && u_idx == r_idx[i];
      hit_n[i] = bus.rd_en[i] && state == IDLE && (r_byp[i] || vld[r_idx[i]])
                 && (r_byp[i] ? u_tag : tags[r_idx[i]]) == r_pc[i][AWIDTH+TWIDTH+1:AWIDTH+2];
      tkn_n[i] = hit_n[i] && (r_byp[i] ? u_ctr[1] : ctrs[r_idx[i]][1]);
      tgt_n[i*DWIDTH +: DWIDTH] = hit_n[i] ? (r_byp[i] ? u_tgt : tgts[r_idx[i]]) : '0;
    end
  end
  always_ff @(posedge clk)
    if (reset) begin
      bus.rd_hit    <= '0;
      bus.rd_taken  <= '0;
      bus.rd_target <= '0;
    end else begin
      bus.rd_hit    <= hit_n;
      bus.rd_taken  <= tkn_n;
      bus.rd_target <= tgt_n;
    end
endmodule

// File: tb/tb_branch_target_buffer.sv
// tb_branch_target_buffer: directed and random traffic checked against an entry-level BTB model.
module tb_branch_target_buffer;
  localparam int AW = 6;
  localparam int DEPTH = 2**AW;
  logic clk, reset;
  int n_asrt, n_fail, busy_cnt;
  bit mv [DEPTH];
  bit [7:0] mt [DEPTH];
  bit [31:0] mg [DEPTH];
  int mc [DEPTH];
  branch_target_buffer_if #(.NRD(2), .DWIDTH(32)) bus ();
  branch_target_buffer #(.AWIDTH(AW), .TWIDTH(8), .DWIDTH(32), .NRD(2)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asrt++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int idx_of(input bit [31:0] pc);
    return int'((pc >> 2) % DEPTH);
  endfunction

  function automatic bit [7:0] tag_of(input bit [31:0] pc);
    return 8'((pc >> (AW + 2)) & 32'hFF);
  endfunction

  task automatic model_upd(input bit [31:0] pc, input bit tk, input bit [31:0] tg);
    int i = idx_of(pc);
    if (mv[i] && mt[i] == tag_of(pc)) begin
      mc[i] = tk ? (mc[i] == 3 ? 3 : mc[i] + 1) : (mc[i] == 0 ? 0 : mc[i] - 1);
      if (tk) mg[i] = tg;
    end else if (tk) begin
      mv[i] = 1'b1;
      mt[i] = tag_of(pc);
      mg[i] = tg;
      mc[i] = 2;
    end
  endtask

  task automatic cyc(input bit r, input bit [1:0] re, input bit [31:0] p0, input bit [31:0] p1,
                     input bit ue, input bit [31:0] upc, input bit ut, input bit [31:0] utg, input bit fl);
    bit [31:0] pcs [2];
    bit eh [2], et [2];
    bit [31:0] eg [2];
    int k;
    reset = r;
    bus.rd_en = re;
    bus.rd_pc = {p1, p0};
    bus.upd_en = ue;
    bus.upd_pc = upc;
    bus.upd_taken = ut;
    bus.upd_target = utg;
    bus.flush_req = fl;
    pcs[0] = p0;
    pcs[1] = p1;
    for (int i = 0; i < 2; i++) begin
      eh[i] = 0;
      et[i] = 0;
      eg[i] = 0;
    end
    if (r) begin
      busy_cnt = DEPTH;
      for (int j = 0; j < DEPTH; j++) mv[j] = 0;
    end else if (busy_cnt > 0) busy_cnt--;
    else begin
      if (ue && !fl) model_upd(upc, ut, utg);
      for (int i = 0; i < 2; i++) begin
        k = idx_of(pcs[i]);
        eh[i] = re[i] && mv[k] && mt[k] == tag_of(pcs[i]);
        et[i] = eh[i] && mc[k] >= 2;
        eg[i] = eh[i] ? mg[k] : 32'h0;
      end
      if (fl) begin
        busy_cnt = DEPTH;
        for (int j = 0; j < DEPTH; j++) mv[j] = 0;
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("rd_hit[%0d] pc=%0h", i, pcs[i]), 64'(bus.rd_hit[i]), 64'(eh[i]));
      check($sformatf("rd_taken[%0d] pc=%0h", i, pcs[i]), 64'(bus.rd_taken[i]), 64'(et[i]));
      check($sformatf("rd_target[%0d] pc=%0h", i, pcs[i]), 64'(bus.rd_target[i*32 +: 32]), 64'(eg[i]));
    end
    check("busy", 64'(bus.busy), 64'(busy_cnt > 0));
  endtask

  function automatic bit [31:0] rpc();
    return ($urandom & 32'hFFFF_0003) | (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 7)) << 2);
  endfunction

  initial begin
    n_asrt = 0;
    n_fail = 0;
    busy_cnt = 0;
    repeat (3) cyc(1, 2'b11, 32'h100, 32'h100, 1, 32'h100, 1, 32'h77, 0);
    cyc(0, 2'b11, 32'h100, 32'h104, 1, 32'h100, 1, 32'h999, 0);
    repeat (63) cyc(0, 2'b11, 32'h100, 32'h104, 0, 0, 0, 0, 0);
    cyc(0, 2'b11, 32'h100, 32'h104, 0, 0, 0, 0, 0);
    cyc(0, 2'b00, 0, 0, 1, 32'h100, 1, 32'h200, 0);
    cyc(0, 2'b11, 32'h100, 32'h100, 0, 0, 0, 0, 0);
    repeat (3) cyc(0, 2'b00, 0, 0, 1, 32'h100, 0, 32'h555, 0);
    cyc(0, 2'b11, 32'h100, 32'h100, 0, 0, 0, 0, 0);
    cyc(0, 2'b01, 32'h100, 0, 1, 32'h100, 1, 32'h300, 0);
    cyc(0, 2'b11, 32'h200, 32'h100, 0, 0, 0, 0, 0);
    cyc(0, 2'b00, 0, 0, 1, 32'h200, 1, 32'h400, 0);
    cyc(0, 2'b11, 32'h100, 32'h200, 0, 0, 0, 0, 0);
    cyc(0, 2'b11, 32'h100, 32'h200, 1, 32'h104, 1, 32'h500, 1);
    for (int c = 0; c < DEPTH; c++)
      cyc(0, 2'b11, 32'h200, 32'h104, c == 10, 32'h104, 1, 32'h600, c == 10);
    cyc(0, 2'b11, 32'h200, 32'h104, 0, 0, 0, 0, 0);
    for (int c = 0; c < 3000; c++)
      cyc($urandom_range(0, 1499) == 0, 2'($urandom), rpc(), rpc(),
          $urandom_range(0, 2) != 0, rpc(), 1'($urandom), $urandom,
          $urandom_range(0, 299) == 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule

// File: doc/branch_target_buffer.md
BRANCH_TARGET_BUFFER -- requirements
Module: branch_target_buffer

Interface
REQ-001 SHALL have parameter AWIDTH, default 6, index bits (DEPTH = 2**AWIDTH entries).
REQ-002 SHALL have parameter TWIDTH, default 8, tag bits per entry.
REQ-003 SHALL have parameter DWIDTH, default 32, width of the PC and the target.
REQ-004 SHALL have parameter NRD, default 2, number of independent read channels.
REQ-005 SHALL have port clk  in  1  clock; all state updates on the rising edge.
REQ-006 SHALL have port reset  in  1  reset; synchronous, active-high.
REQ-007 SHALL have port rd_en  in  NRD  per-channel lookup request.
REQ-008 SHALL have port rd_pc  in  NRD*DWIDTH  lookup PCs; channel i occupies bits [i*DWIDTH +: DWIDTH].
REQ-009 SHALL have port rd_hit  out  NRD  registered; valid entry with matching tag.
REQ-010 SHALL have port rd_taken  out  NRD  registered; rd_hit AND counter MSB.
REQ-011 SHALL have port rd_target  out  NRD*DWIDTH  registered stored target; zero when rd_hit=0.
REQ-012 SHALL have port upd_en  in  1  resolved-branch update strobe.
REQ-013 SHALL have port upd_pc  in  DWIDTH  PC of the resolved branch.
REQ-014 SHALL have port upd_taken  in  1  resolved direction.
REQ-015 SHALL have port upd_target  in  DWIDTH  resolved target.
REQ-016 SHALL have port flush_req  in  1  single-cycle request to invalidate all entries.
REQ-017 SHALL have port busy  out  1  high while the clear sequence runs.

Function
REQ-018 SHALL derive index = pc[AWIDTH+1:2] and tag = pc[AWIDTH+TWIDTH+1:AWIDTH+2].
REQ-019 SHALL store per entry: valid, tag, DWIDTH target, 2-bit saturating counter (00 SNT, 01 WNT, 10 WT, 11 ST).
REQ-020 SHALL register all read results with exactly 1 cycle latency from rd_en; when rd_en[i]=0, channel i outputs are 0 on the next cycle.
REQ-021 SHALL, on an update hit (valid and tag match), increment the counter on taken and decrement it on not-taken, saturating at 11 and 00.
REQ-022 SHALL overwrite the target only on a taken update hit.
REQ-023 SHALL, on a taken update miss, allocate: valid=1, new tag, target=upd_target, counter=10.
REQ-024 SHALL NOT allocate or modify any entry on a not-taken update miss.
REQ-025 SHALL make a read in the same cycle as an update to the same index return the post-update entry (write-first bypass), for every channel.
REQ-026 SHALL implement FSM states IDLE and CLEAR: IDLE -> CLEAR on flush_req; CLEAR invalidates entry clr_ptr each cycle, clr_ptr counting 0..DEPTH-1; CLEAR -> IDLE after entry DEPTH-1 is cleared.
REQ-027 SHALL hold busy=1 exactly in CLEAR, for DEPTH consecutive cycles.
REQ-028 SHALL, while in CLEAR, drop updates and force rd_hit=rd_taken=0 and rd_target=0 for every read.
REQ-029 SHALL ignore flush_req while in CLEAR, without restarting the sequence.
REQ-030 SHALL process an update and a flush_req arriving in the same IDLE cycle as flush only; the update is dropped.

Reset
REQ-031 SHALL, on reset, set rd_hit, rd_taken and rd_target to 0, set clr_ptr to 0, and enter CLEAR.
REQ-032 SHALL, on reset, hold busy=1 for DEPTH cycles after reset deasserts.
REQ-033 SHALL restart the clear from entry 0 when reset asserts mid-CLEAR.
REQ-034 SHALL leave tag, target and counter arrays un-reset; only valid is cleared, by the FSM.

Structure
REQ-035 SHALL place the counter encodings, counter reset value 10, and the IDLE/CLEAR state encoding in shared package bp_pkg.
REQ-036 SHALL implement counter next-state logic in sub-module bp_sat_counter (2-bit in, taken in, 2-bit out).
REQ-037 SHALL keep arrays single-write and NRD+1-read, inferable as distributed RAM or flops.

Verification
REQ-038 SHALL cover: reset released -> busy high 64 cycles (AWIDTH=6), and any read during that window -> rd_hit=0.
REQ-039 SHALL cover: update pc=0x100, taken, target=0x200, then read 0x100 -> next cycle rd_hit=1, rd_taken=1, rd_target=0x200.
REQ-040 SHALL cover: three not-taken updates to 0x100 -> counter 10->01->00->00; read -> rd_hit=1, rd_taken=0, rd_target still 0x200.
REQ-041 SHALL cover: read 0x100 on ch0 in the same cycle as a taken update to 0x100 with target 0x300 -> ch0 returns rd_target=0x300.
REQ-042 SHALL cover: alias pc=0x100+(1<<(AWIDTH+2)), read -> rd_hit=0; a taken update to it evicts 0x100, so 0x100 then misses.
REQ-043 SHALL cover: flush_req with an update in the same cycle -> busy DEPTH cycles, update lost, all reads miss afterwards; a second flush_req mid-CLEAR does not extend busy.
